// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the mac_pipe multiply-accumulate engine.
//   mac_mode_e  : per-frame arithmetic mode (unsigned / signed)
//   mac_state_e : frame tracking state (IDLE / IN_FRAME)
//   s1_t, s2_t  : per-beat control payload carried alongside the data pipeline
package mac_pkg;

    localparam int unsigned MAC_DATA_W_DEF = 16;
    localparam int unsigned MAC_ACC_W_DEF  = 40;
    localparam int unsigned MAC_CNT_W_DEF  = 8;

    typedef enum logic {
        MAC_UNSIGNED = 1'b0,
        MAC_SIGNED   = 1'b1
    } mac_mode_e;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } mac_state_e;

    // Control for a beat held in stage 1 (operands are kept in separate registers).
    typedef struct packed {
        logic      vld;
        logic      first;
        logic      last;
        mac_mode_e mode;
    } s1_t;

    // Control for a beat held in stage 2 / the accumulate-stage input register.
    typedef struct packed {
        logic      vld;
        logic      first;
        logic      last;
        mac_mode_e mode;
    } s2_t;

endpackage

// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand-beat input channel and result output channel of mac_pipe.
//   master : the operand source / result sink (testbench or upstream datapath)
//   slave  : the mac_pipe engine
//   in_valid/in_ready, in_first/in_last, in_signed, a, b, acc_in : operand beats
//   out_valid/out_ready, acc_out, out_count, overflow            : frame results
interface mac_pipe_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W_DEF,
    parameter int unsigned ACC_W  = MAC_ACC_W_DEF,
    parameter int unsigned CNT_W  = MAC_CNT_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic              in_signed;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ACC_W-1:0]  acc_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  out_count;
    logic              overflow;

    modport master (
        output in_valid, in_first, in_last, in_signed, a, b, acc_in, out_ready,
        input  in_ready, out_valid, acc_out, out_count, overflow
    );

    modport slave (
        input  in_valid, in_first, in_last, in_signed, a, b, acc_in, out_ready,
        output in_ready, out_valid, acc_out, out_count, overflow
    );

endinterface

// File: rtl/mac_acc_sat.sv
// mac_acc_sat: combinational accumulate step with overflow detection.
//   base_i   : running accumulator (or frame seed on a first beat)
//   addend_i : extended product
//   mode_i   : frame mode; selects signed or unsigned overflow rule
//   sum_c_o  : base + addend (clamped on overflow when MAC_SAT_EN is defined, else wrapped)
//   ovf_c_o  : this addition left the representable range
// Build option: MAC_SAT_EN (defined -> saturate, undefined -> wrap modulo 2^ACC_W).
module mac_acc_sat
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = MAC_ACC_W_DEF
) (
    input  logic [ACC_W-1:0] base_i,
    input  logic [ACC_W-1:0] addend_i,
    input  mac_mode_e        mode_i,
    output logic [ACC_W-1:0] sum_c_o,
    output logic             ovf_c_o
);

    logic [ACC_W:0] raw;
    logic           msb_cin;

    always_comb begin
        raw     = {1'b0, base_i} + {1'b0, addend_i};
        // Carry into the MSB recovered from the MSB sum bit.
        msb_cin = base_i[ACC_W-1] ^ addend_i[ACC_W-1] ^ raw[ACC_W-1];
        ovf_c_o = (mode_i == MAC_SIGNED) ? (msb_cin ^ raw[ACC_W]) : raw[ACC_W];
        sum_c_o = raw[ACC_W-1:0];
`ifdef MAC_SAT_EN
        if (ovf_c_o) begin
            if (mode_i == MAC_SIGNED) begin
                // Signed overflow needs equal operand signs; the base sign gives the direction.
                sum_c_o = base_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                sum_c_o = '1;
            end
        end
`endif
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate engine, one dot product per framed burst.
//   clk, rst          : clock, synchronous active-low reset
//   scan_en, scanin   : DFT scan hooks, no functional effect
//   scanout           : DFT scan output, tied low until scan insertion
//   bus (slave)       : operand beats in, frame results out (see mac_pipe_if)
// Pipeline: S1 operands -> S2 product -> S3 extended addend -> accumulate -> output register.
// Build option: MAC_SAT_EN selects saturating accumulation (see mac_acc_sat).
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W_DEF,
    parameter int unsigned ACC_W  = MAC_ACC_W_DEF,
    parameter int unsigned CNT_W  = MAC_CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      scan_en,
    input  logic      scanin,
    output logic      scanout,
    mac_pipe_if.slave bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
        $error("mac_pipe: ACC_W must be at least 2*DATA_W");
    end

    logic unused_scan;
    assign unused_scan = scan_en ^ scanin;
    assign scanout     = 1'b0;

    // Global advance: the whole pipeline freezes while a result waits for out_ready.
    logic out_valid_q;
    logic adv;
    logic accept;

    assign adv          = !(out_valid_q && !bus.out_ready);
    assign accept       = bus.in_valid && adv;
    assign bus.in_ready = adv;

    // Frame tracking and mode capture at the input.
    mac_state_e state_q;
    mac_mode_e  mode_q;
    logic       beat_first;
    mac_mode_e  beat_mode;

    always_comb begin
        beat_first = bus.in_first || (state_q == IDLE);
        beat_mode  = mode_q;
        if (beat_first) begin
            beat_mode = bus.in_signed ? MAC_SIGNED : MAC_UNSIGNED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= MAC_UNSIGNED;
        end else if (accept) begin
            state_q <= bus.in_last ? IDLE : IN_FRAME;
            mode_q  <= beat_mode;
        end
    end

    // S1: operands, seed and beat control.
    s1_t               s1_d;
    s1_t               s1_q;
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] b1_q;
    logic [ACC_W-1:0]  seed1_q;

    always_comb begin
        s1_d       = '0;
        s1_d.vld   = bus.in_valid;
        s1_d.first = beat_first;
        s1_d.last  = bus.in_last;
        s1_d.mode  = beat_mode;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            seed1_q <= '0;
        end else if (adv) begin
            s1_q    <= s1_d;
            a1_q    <= bus.a;
            b1_q    <= bus.b;
            seed1_q <= bus.acc_in;
        end
    end

    // S2: product. Operands are widened per mode, so the low PROD_W bits of an
    // unsigned multiply are the correct signed or unsigned product.
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;
    s2_t               s2_d;
    s2_t               s2_q;
    logic [ACC_W-1:0]  seed2_q;

    always_comb begin
        a_ext = {{DATA_W{1'b0}}, a1_q};
        b_ext = {{DATA_W{1'b0}}, b1_q};
        if (s1_q.mode == MAC_SIGNED) begin
            a_ext = {{DATA_W{a1_q[DATA_W-1]}}, a1_q};
            b_ext = {{DATA_W{b1_q[DATA_W-1]}}, b1_q};
        end
        prod_d     = a_ext * b_ext;
        s2_d       = '0;
        s2_d.vld   = s1_q.vld;
        s2_d.first = s1_q.first;
        s2_d.last  = s1_q.last;
        s2_d.mode  = s1_q.mode;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_q    <= '0;
            prod_q  <= '0;
            seed2_q <= '0;
        end else if (adv) begin
            s2_q    <= s2_d;
            prod_q  <= prod_d;
            seed2_q <= seed1_q;
        end
    end

    // S3 input: product extended to ACC_W per mode.
    logic [ACC_W-1:0] ext_d;
    logic [ACC_W-1:0] ext_q;
    logic [ACC_W-1:0] seed3_q;
    s2_t              s3_q;

    always_comb begin
        ext_d = ACC_W'(prod_q);
        if (s2_q.mode == MAC_SIGNED) begin
            ext_d = ACC_W'($signed(prod_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_q    <= '0;
            ext_q   <= '0;
            seed3_q <= '0;
        end else if (adv) begin
            s3_q    <= s2_q;
            ext_q   <= ext_d;
            seed3_q <= seed2_q;
        end
    end

    // S3: accumulate. A first beat reseeds, which also discards an aborted frame's partial sum.
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_q;
    logic             ovf_next;
    logic             add_ovf;

    always_comb begin
        acc_base = s3_q.first ? seed3_q : acc_q;
        cnt_next = CNT_W'(1);
        if (!s3_q.first) begin
            cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
        ovf_next = add_ovf || (!s3_q.first && ovf_q);
    end

    mac_acc_sat #(
        .ACC_W (ACC_W)
    ) u_acc_sat (
        .base_i   (acc_base),
        .addend_i (ext_q),
        .mode_i   (s3_q.mode),
        .sum_c_o  (acc_next),
        .ovf_c_o  (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv && s3_q.vld) begin
            acc_q <= acc_next;
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

    // Output register: loads on a frame's last beat; may reload in the handshake cycle.
    logic [ACC_W-1:0] acc_out_q;
    logic [CNT_W-1:0] cnt_out_q;
    logic             ovf_out_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            cnt_out_q   <= '0;
            ovf_out_q   <= 1'b0;
        end else if (adv && s3_q.vld && s3_q.last) begin
            out_valid_q <= 1'b1;
            acc_out_q   <= acc_next;
            cnt_out_q   <= cnt_next;
            ovf_out_q   <= ovf_next;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.out_count = cnt_out_q;
    assign bus.overflow  = ovf_out_q;

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined multiply-accumulate engine that replaces the fixed 16x16→32 `mac` in the synthesis lab datapath. It takes a stream of operand pairs in framed bursts (`in_first`/`in_last`), accumulates one dot product per frame at full throughput, and emits each result through a valid/ready output register. It adds configurable width, signed or unsigned mode per frame, overflow detection, beat counting and back-pressure. Scan ports are kept so the Genus DFT flow can stitch the chain.

## Interface
- `DATA_W`, 16: operand width.
- `ACC_W`, 40: accumulator and result width. Elaboration fails if `ACC_W < 2*DATA_W`.
- `CNT_W`, 8: beat-counter width.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `scan_en`  in  1  DFT scan enable. No functional effect in RTL.
- `scanin`  in  1  DFT scan input. No functional effect in RTL.
- `scanout`  out  1  DFT scan output. RTL drives 0; replaced at DFT insertion.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_first`  in  1  beat opens a frame.
- `in_last`  in  1  beat closes a frame.
- `in_signed`  in  1  frame mode. Sampled on the first beat only.
- `a`, `b`  in  DATA_W each  operands.
- `acc_in`  in  ACC_W  accumulator seed. Sampled on the first beat.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `acc_out`  out  ACC_W  frame result.
- `out_count`  out  CNT_W  number of beats in the frame. Saturates at `2^CNT_W-1`.
- `overflow`  out  1  sticky for the frame: the accumulator left the representable range.

## Operation
- **Stage 1 (S1):** registers `a`, `b`, the first/last flags and the mode.
- **Stage 2 (S2):** registers the 2·DATA_W product, then sign-extends (signed mode) or zero-extends (unsigned mode) it to ACC_W.
- **Stage 3 (S3):** accumulates.
  - First beat: `acc = acc_in + prod`, `count = 1`, `overflow` is cleared and then evaluated.
  - Other beats: `acc += prod`, `count++`.
- **Last beat in S3:** the output register loads `acc_next`, `count_next` and `ovf_next`; `out_valid` goes to 1.
- **Frame state machine:** two states, IDLE and IN_FRAME.
  - A beat with `in_first` enters IN_FRAME. A beat with `in_last` returns to IDLE.
  - A beat with both flags set is a single-beat frame.
- **Beat in IDLE without `in_first`:** treated as a first beat.
- **`in_first` while IN_FRAME:** aborts the open frame with no output, and a new frame starts.
- **Overflow detection:** signed mode uses the carry into vs. out of the MSB; unsigned mode uses the carry-out.
- **Stall rule:** `in_ready = !(out_valid && !out_ready)`. All stages advance only when `in_ready` is 1. When stalled the pipeline freezes and the output holds.
- **Reset:** `out_valid`=0, `acc_out`=0, `out_count`=0, `overflow`=0, `in_ready`=1 during and after reset. All stage valids are cleared, the state machine goes to IDLE, and any in-flight frame is discarded with no output.

## Timing
- Throughput is one beat per cycle.
- Latency: a last beat accepted at edge E0 gives `out_valid`=1 after edge E0+3.
- The output handshake and a new result loading in the same cycle is legal: the register reloads with no bubble.
- `in_ready` depends combinationally on `out_ready`. No other input→output combinational paths exist.
- The mode is fixed for the whole frame. A change of `in_signed` mid-frame is ignored.
- `acc_in` of non-first beats is ignored.

## Configuration
- **`MAC_SAT_EN` defined:** on overflow, S3 clamps to the max/min representable value for the frame's mode. Accumulation continues from the clamped value, and `overflow` is set.
- **`MAC_SAT_EN` undefined:** the accumulator wraps modulo 2^ACC_W. `overflow` is still flagged.

## Structure
- **Package `mac_pkg`:**
  - `mac_mode_e` enum: `MAC_UNSIGNED`, `MAC_SIGNED`.
  - `mac_state_e` enum: `IDLE`, `IN_FRAME`.
  - Stage payload structs `s1_t` and `s2_t`.
- **Sub-module `mac_acc_sat`:** combinational add, overflow detect, and saturate under `MAC_SAT_EN`. Instantiated once, in S3.

## Test plan
- **Reset behaviour:** hold `rst`=0 for 2 cycles, then release.
  - All outputs are 0 and `in_ready`=1.
  - A frame that is mid-pipeline when reset asserts produces no output.
- **Unsigned 3-beat frame, `acc_in`=5:** operands (2,3), (4,5), (1,1), `out_ready`=1.
  - Expect `acc_out`=32, `out_count`=3, `overflow`=0.
  - `out_valid` rises 3 cycles after the last beat is accepted.
- **Signed single-beat frame (`first`=`last`=1):** a=0xFFFF (−1), b=0x0002.
  - Expect `acc_out` = −2, sign-extended to 40 bits.
  - In unsigned mode the same operands give 131070.
- **Back-pressure:** hold `out_ready`=0 with a result pending while a second frame streams in.
  - `in_ready` drops to 0 and the first result holds unchanged.
  - Raising `out_ready` releases both results in order with no beat lost.
- **Overflow:** `ACC_W`=32, signed, `acc_in`=0x7FFF0000, one beat of 0x7FFF×0x7FFF.
  - With `MAC_SAT_EN`: `acc_out`=0x7FFFFFFF, `overflow`=1.
  - Without `MAC_SAT_EN`: the result is the wrapped value, `overflow`=1.
- **Frame abort:** send `in_first` on beat 3 of an open frame.
  - No output for the aborted frame.
  - The new frame's result counts only its own beats.
